// File: rtl/alu_accum_ctrl.sv
// Accumulator command sequencer for an external combinational 8-bit add/sub ALU.
// Each command runs IDLE -> EXEC -> RESP; the ALU result is captured at the end of EXEC.
module alu_accum_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [1:0]       io_cmd_op,
  input  logic [WIDTH-1:0] io_cmd_data,
  output logic [WIDTH-1:0] io_alu_a,
  output logic [WIDTH-1:0] io_alu_b,
  output logic             io_alu_sel,
  input  logic [WIDTH-1:0] io_alu_result,
  input  logic             io_alu_overflow,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [WIDTH-1:0] io_resp_acc,
  output logic             io_resp_overflow,
  output logic             io_resp_zero,
  output logic             io_sticky_ovf,
  output logic [7:0]       io_op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [1:0] {OP_CLR, OP_LOAD, OP_ADD, OP_SUB} op_t;

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic             ovf_q;
  logic             sticky_q;
  logic [7:0]       count_q;
  logic             cmd_ready_q;
  logic             resp_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_CLR;
      acc_q        <= '0;
      b_q          <= '0;
      ovf_q        <= 1'b0;
      sticky_q     <= 1'b0;
      count_q      <= '0;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_cmd_valid) begin
            op_q        <= op_t'(io_cmd_op);
            b_q         <= io_cmd_data;
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_CLR: begin
              acc_q    <= '0;
              ovf_q    <= 1'b0;
              sticky_q <= 1'b0;
            end
            OP_LOAD: begin
              acc_q <= b_q;
              ovf_q <= 1'b0;
            end
            default: begin
              acc_q    <= io_alu_result;
              ovf_q    <= io_alu_overflow;
              sticky_q <= sticky_q | io_alu_overflow;
            end
          endcase
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (io_resp_ready) begin
            count_q      <= count_q + 8'd1;
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          cmd_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // ALU operands come straight from registers so the EXEC-cycle sample is stable.
  assign io_alu_a         = acc_q;
  assign io_alu_b         = b_q;
  assign io_alu_sel       = (op_q == OP_SUB);
  assign io_cmd_ready     = cmd_ready_q;
  assign io_resp_valid    = resp_valid_q;
  assign io_resp_acc      = acc_q;
  assign io_resp_overflow = ovf_q;
  assign io_resp_zero     = (acc_q == '0);
  assign io_sticky_ovf    = sticky_q;
  assign io_op_count      = count_q;

endmodule
